dm_arbiter: RTL

- Two-port arbiter and sequencer in front of the data memory (DM).
- Port 0 is the pipeline MEM-stage load/store path and has priority. Port 1 is a secondary master (debug/DMA loader).
- Selects at most one access per cycle and drives DM's WE/A/WD/LS_op/PC.
- Returns a registered ack, error flag and read data to the winning port one cycle after issue.
- Enforces alignment and bounds port 1 starvation.

---
 rtl/dm_arbiter_if.sv | 52 +++++
 rtl/dm_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two DM requesters, the arbiter and the data memory.
// The arbiter uses the slave modport; requesters and the DM together use master.
interface dm_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  // Port 0: MEM-stage load/store path
  logic              req0;
  logic              we0;
  logic [1:0]        ls_op0;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] pc0;
  logic              ack0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  // Port 1: debug/DMA loader
  logic              req1;
  logic              we1;
  logic [1:0]        ls_op1;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  // Data memory side
  logic              dm_we;
  logic [1:0]        dm_ls_op;
  logic [DATA_W-1:0] dm_a;
  logic [DATA_W-1:0] dm_wd;
  logic [DATA_W-1:0] dm_pc;
  logic [DATA_W-1:0] dm_rd;

  modport slave (
    input  req0, we0, ls_op0, addr0, wdata0, pc0,
    output ack0, err0, rdata0,
    input  req1, we1, ls_op1, addr1, wdata1,
    output ack1, err1, rdata1,
    output dm_we, dm_ls_op, dm_a, dm_wd, dm_pc,
    input  dm_rd
  );

  modport master (
    output req0, we0, ls_op0, addr0, wdata0, pc0,
    input  ack0, err0, rdata0,
    output req1, we1, ls_op1, addr1, wdata1,
    input  ack1, err1, rdata1,
    input  dm_we, dm_ls_op, dm_a, dm_wd, dm_pc,
    output dm_rd
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: port 0 has priority, port 1 is protected from
// starvation; one access per cycle, registered ack/err/rdata one cycle later.
module dm_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned DATA_W     = 32
) (
  input logic          clk,
  input logic          reset,
  dm_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    LS_W = 2'b00,
    LS_H = 2'b01,
    LS_B = 2'b10
  } ls_op_e;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_starved;
  logic              w_sel0;
  logic              w_sel1;
  logic              w_we;
  logic              w_aligned;
  logic [1:0]        w_ls_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_wd;
  logic [DATA_W-1:0] w_pc;

  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [CNT_W-1:0]  r_starve_cnt;

  // A port whose ack is high this cycle is still finishing its last access.
  assign w_elig0   = bus.req0 & ~r_ack0 & ~reset;
  assign w_elig1   = bus.req1 & ~r_ack1 & ~reset;
  assign w_starved = (r_starve_cnt >= CNT_W'(STARVE_MAX));
  assign w_sel1    = w_elig1 & (~w_elig0 | w_starved);
  assign w_sel0    = w_elig0 & ~w_sel1;

  always_comb begin
    w_we    = 1'b0;
    w_ls_op = '0;
    w_a     = '0;
    w_wd    = '0;
    w_pc    = '0;
    if (w_sel0) begin
      w_we    = bus.we0;
      w_ls_op = bus.ls_op0;
      w_a     = bus.addr0;
      w_wd    = bus.wdata0;
      w_pc    = bus.pc0;
    end else if (w_sel1) begin
      w_we    = bus.we1;
      w_ls_op = bus.ls_op1;
      w_a     = bus.addr1;
      w_wd    = bus.wdata1;
    end
  end

  always_comb begin
    w_aligned = 1'b1;
    case (w_ls_op)
      LS_W:    w_aligned = (w_a[1:0] == 2'b00);
      LS_H:    w_aligned = ~w_a[0];
      default: w_aligned = 1'b1;
    endcase
  end

  assign bus.dm_we    = w_we & w_aligned & ~reset;
  assign bus.dm_ls_op = w_ls_op;
  assign bus.dm_a     = w_a;
  assign bus.dm_wd    = w_wd;
  assign bus.dm_pc    = w_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_ack0 <= w_sel0;
      r_ack1 <= w_sel1;
      if (w_sel0) begin
        r_err0   <= ~w_aligned;
        r_rdata0 <= (!w_we && w_aligned) ? bus.dm_rd : '0;
      end
      if (w_sel1) begin
        r_err1   <= ~w_aligned;
        r_rdata1 <= (!w_we && w_aligned) ? bus.dm_rd : '0;
      end
      if (!bus.req1 || w_sel1) begin
        r_starve_cnt <= '0;
      end else if (w_elig1 && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  // Registered completions are masked while reset is high so an ack already
  // in flight when reset arrives is never seen; the requester must retry.
  assign bus.ack0   = r_ack0 & ~reset;
  assign bus.ack1   = r_ack1 & ~reset;
  assign bus.err0   = r_err0 & ~reset;
  assign bus.err1   = r_err1 & ~reset;
  assign bus.rdata0 = reset ? '0 : r_rdata0;
  assign bus.rdata1 = reset ? '0 : r_rdata1;
endmodule
